// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : default 640x480@60 timing constants and shared coordinate type
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int CLK_DIV  = 2;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [9:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// vga_timing_gen_if : raster outputs toward the VGA DAC and the grid painter
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   vga_clk;
  logic   hsync;
  logic   vsync;
  logic   sync_b;
  logic   blank_b;
  coord_t x;
  coord_t y;
  logic   frame_start;

  modport master (
    output vga_clk, hsync, vsync, sync_b, blank_b, x, y, frame_start
  );

  modport slave (
    input  vga_clk, hsync, vsync, sync_b, blank_b, x, y, frame_start
  );

endinterface

`default_nettype wire

// File: rtl/clk_en_div.sv
// ============================================================================
// clk_en_div : pixel-rate enable and registered DAC pixel clock
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_en_div #(
  parameter int CLK_DIV = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  output logic pix_en_o,
  output logic vga_clk_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] C_DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;
  logic          vga_clk_q;

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    if (div_cnt_q == C_DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  // vga_clk follows the next divider phase so it is low for the first half
  // of each pixel and rises mid-pixel, clear of any output change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      vga_clk_q <= (div_cnt_d >= C_DIV_HALF);
    end
  end

  assign pix_en_o  = (div_cnt_q == C_DIV_LAST);
  assign vga_clk_o = vga_clk_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// vga_timing_gen : raster scan counters with registered sync/blank decode
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = vga_pkg::CLK_DIV
) (
  input  wire              clk,
  input  wire              rst_n,
  vga_timing_gen_if.master vga
);

  localparam coord_t C_H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t C_V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t C_H_ACTIVE = coord_t'(H_ACTIVE);
  localparam coord_t C_V_ACTIVE = coord_t'(V_ACTIVE);
  localparam coord_t C_HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t C_HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t C_VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t C_VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic   pix_en;
  logic   vga_clk_w;
  coord_t hcnt_q, hcnt_d;
  coord_t vcnt_q, vcnt_d;
  coord_t x_q, y_q;
  logic   hsync_q, vsync_q, blank_b_q, frame_start_q;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en_o  (pix_en),
    .vga_clk_o (vga_clk_w)
  );

  // hcnt/vcnt name the pixel presented on the next pix_en edge.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == C_H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == C_V_LAST) ? coord_t'(0) : vcnt_q + coord_t'(1);
      end else begin
        hcnt_d = hcnt_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_b_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (pix_en) begin
        x_q           <= hcnt_q;
        y_q           <= vcnt_q;
        hsync_q       <= !((hcnt_q >= C_HS_START) && (hcnt_q < C_HS_END));
        vsync_q       <= !((vcnt_q >= C_VS_START) && (vcnt_q < C_VS_END));
        blank_b_q     <= (hcnt_q < C_H_ACTIVE) && (vcnt_q < C_V_ACTIVE);
        frame_start_q <= (hcnt_q == '0) && (vcnt_q == '0);
      end
    end
  end

  assign vga.vga_clk     = vga_clk_w;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.sync_b      = 1'b0;
  assign vga.blank_b     = blank_b_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;

endmodule

`default_nettype wire
